// File: rtl/bcd_seg_scan_pkg.sv
// Shared 7-segment definitions for the display blocks.
// Patterns are "on" patterns ordered {g,f,e,d,c,b,a}; polarity is applied by the user.
package bcd_seg_scan_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Non-BCD codes (10..15) show a dash so a corrupted counter is visible.
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] bcd);
    logic [SEG_W-1:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Digit input / display output bundle of the scanned 7-segment driver.
interface bcd_seg_scan_if #(
  parameter int NDIG = 4
);
  import bcd_seg_scan_pkg::*;

  logic [4*NDIG-1:0] DIGITS;
  logic [NDIG-1:0]   DP_IN;
  logic              LZB;
  logic [SEG_W-1:0]  SEG;
  logic              DP;
  logic [NDIG-1:0]   AN;
  logic              FRAME;

  // Source of the digits (counter side / bench)
  modport master (
    output DIGITS, DP_IN, LZB,
    input  SEG, DP, AN, FRAME
  );

  // Display driver
  modport slave (
    input  DIGITS, DP_IN, LZB,
    output SEG, DP, AN, FRAME
  );
endinterface

// File: rtl/bcd_seg_dec.sv
// Combinational BCD to 7-segment "on" pattern decoder.
module bcd_seg_dec
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 7-segment scanner with per-frame digit snapshot,
// leading-zero blanking and one dead-time clock at the start of each slot.
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  bcd_seg_scan_if.slave bus
);

  localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam bit POL = (ACTIVE_LOW != 0);

  logic [PW-1:0]     pcnt_reg;
  logic [IW-1:0]     idx_reg;
  logic [4*NDIG-1:0] snap_digits_reg;
  logic [NDIG-1:0]   snap_dp_reg;
  logic              snap_lzb_reg;
  logic [NDIG-1:0]   an_reg;
  logic [SEG_W-1:0]  seg_reg;
  logic              dp_reg;
  logic              frame_reg;

  logic [3:0]        digit_arr [NDIG];
  logic [NDIG-1:0]   an_sel;
  logic [NDIG-1:0]   blank;
  logic              lz_run;
  logic [3:0]        cur_digit;
  logic [SEG_W-1:0]  dec_seg;
  logic              frame_start;
  logic              lit;
  logic [NDIG-1:0]   an_on;
  logic [SEG_W-1:0]  seg_on;
  logic              dp_on;

  // Unpack the snapshot and build the one-hot anode select per digit.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      assign digit_arr[gi] = snap_digits_reg[4*gi +: 4];
      assign an_sel[gi]    = (idx_reg == IW'(gi));
    end
  endgenerate

  // Leading-zero mask: zeros from the top digit down until the first non-zero;
  // digit 0 always shows so a value of zero still displays "0".
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lz_run   = lz_run && (digit_arr[i] == 4'd0);
      blank[i] = lz_run && (i != 0);
    end
  end

  assign cur_digit = digit_arr[idx_reg];

  bcd_seg_dec u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  assign frame_start = (pcnt_reg == '0) && (idx_reg == '0);
  assign lit         = (pcnt_reg != '0);
  assign an_on       = lit ? an_sel : '0;
  assign seg_on      = (lit && !(snap_lzb_reg && blank[idx_reg])) ? dec_seg : SEG_BLANK;
  assign dp_on       = lit && snap_dp_reg[idx_reg];

  // Scan counters, frame snapshot and polarity-adjusted output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pcnt_reg        <= '0;
      idx_reg         <= '0;
      snap_digits_reg <= '0;
      snap_dp_reg     <= '0;
      snap_lzb_reg    <= 1'b0;
      an_reg          <= {NDIG{POL}};
      seg_reg         <= {SEG_W{POL}};
      dp_reg          <= POL;
      frame_reg       <= 1'b0;
    end else begin
      if (pcnt_reg == PW'(SCAN_DIV - 1)) begin
        pcnt_reg <= '0;
        idx_reg  <= (idx_reg == IW'(NDIG - 1)) ? '0 : idx_reg + 1'b1;
      end else begin
        pcnt_reg <= pcnt_reg + 1'b1;
      end
      if (frame_start) begin
        snap_digits_reg <= bus.DIGITS;
        snap_dp_reg     <= bus.DP_IN;
        snap_lzb_reg    <= bus.LZB;
      end
      frame_reg <= frame_start;
      an_reg    <= an_on ^ {NDIG{POL}};
      seg_reg   <= seg_on ^ {SEG_W{POL}};
      dp_reg    <= dp_on ^ POL;
    end
  end

  assign bus.AN    = an_reg;
  assign bus.SEG   = seg_reg;
  assign bus.DP    = dp_reg;
  assign bus.FRAME = frame_reg;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: two instances (active-high and active-low outputs)
// share clock, reset and stimulus; an independent frame-position model pushes
// the expected outputs of each edge into a queue that the test tasks pop.
module tb_bcd_seg_scan;

  localparam int NDIG = 4;
  localparam int DIV  = 4;
  localparam int FRM  = NDIG * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        lzb;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_seg_scan_if #(.NDIG(NDIG)) ia ();
  bcd_seg_scan_if #(.NDIG(NDIG)) ib ();

  assign ia.DIGITS = digits;
  assign ia.DP_IN  = dp_in;
  assign ia.LZB    = lzb;
  assign ib.DIGITS = digits;
  assign ib.DP_IN  = dp_in;
  assign ib.LZB    = lzb;

  bcd_seg_scan #(.NDIG(NDIG), .SCAN_DIV(DIV), .ACTIVE_LOW(0)) dut_a (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (ia)
  );

  bcd_seg_scan #(.NDIG(NDIG), .SCAN_DIV(DIV), .ACTIVE_LOW(1)) dut_b (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (ib)
  );

  always #5 CLK = ~CLK;

  // Reference model state: edges since reset release and the frame snapshot.
  int          k;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic        m_lzb;
  exp_t        q[$];
  exp_t        e;
  exp_t        eb;

  logic [6:0] seg_tbl [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000
  };

  function automatic exp_t to_low(input exp_t x);
    exp_t y;
    y.an    = ~x.an;
    y.seg   = ~x.seg;
    y.dp    = ~x.dp;
    y.frame = x.frame;
    return y;
  endfunction

  // Predict the next edge from the frame position, push it, then advance.
  task automatic push_edge();
    exp_t x;
    int   p, slot, off, top;
    logic [3:0] d;
    p    = k % FRM;
    slot = p / DIV;
    off  = p % DIV;
    if (p == 0) begin
      m_digits = digits;
      m_dp     = dp_in;
      m_lzb    = lzb;
    end
    x.frame = (p == 0);
    if (off == 0) begin
      x.an = 4'b0000; x.seg = 7'b0; x.dp = 1'b0;
    end else begin
      top = 0;
      for (int i = 0; i < NDIG; i++)
        if (m_digits[4*i +: 4] != 4'd0) top = i;
      d    = m_digits[4*slot +: 4];
      x.an = 4'b0001 << slot;
      x.seg = (m_lzb && slot > top) ? 7'b0 : seg_tbl[d];
      x.dp = m_dp[slot];
    end
    q.push_back(x);
    k++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; digits = 16'h1234; dp_in = 4'b0100; lzb = 1'b0;
    #12;
    n_tests++;
    if ({ia.AN, ia.SEG, ia.DP, ia.FRAME} !== 13'b0)
      begin n_fail++; $display("FAIL reset_high got %b required %b", {ia.AN, ia.SEG, ia.DP, ia.FRAME}, 13'b0); end
    n_tests++;
    if ({ib.AN, ib.SEG, ib.DP, ib.FRAME} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL reset_low got %b required %b", {ib.AN, ib.SEG, ib.DP, ib.FRAME}, {4'b1111, 7'b1111111, 1'b1, 1'b0}); end
    $display("[TB] reset AN_a=%b AN_b=%b SEG_b=%b DP_b=%b", ia.AN, ib.AN, ib.SEG, ib.DP);
    dp_in = 4'b0000;
    #4;
    RESET = 1'b0;
    k = 0;
  endtask

  task automatic test_scan_1234();
    digits = 16'h1234; lzb = 1'b0; dp_in = 4'b0000;
    for (int n = 0; n < 2 * FRM; n++) begin
      push_edge();
      e = q.pop_front(); eb = to_low(e); n_tests++;
      if ({ia.AN, ia.SEG, ia.DP, ia.FRAME} !== e || {ib.AN, ib.SEG, ib.DP, ib.FRAME} !== eb) begin
        n_fail++;
        $display("FAIL scan_1234 k=%0d got a=%b b=%b required a=%b b=%b", k, {ia.AN, ia.SEG, ia.DP, ia.FRAME}, {ib.AN, ib.SEG, ib.DP, ib.FRAME}, e, eb);
      end else
        $display("[TB] scan_1234 k=%0d AN=%b SEG=%b DP=%b FRAME=%b", k, ia.AN, ia.SEG, ia.DP, ia.FRAME);
    end
  endtask

  task automatic test_lzb();
    logic [15:0] pats [2] = '{16'h0070, 16'h0000};
    lzb = 1'b1; dp_in = 4'b0000;
    for (int t = 0; t < 2; t++) begin
      digits = pats[t];
      for (int n = 0; n < 2 * FRM; n++) begin
        push_edge();
        e = q.pop_front(); eb = to_low(e); n_tests++;
        if ({ia.AN, ia.SEG, ia.DP, ia.FRAME} !== e || {ib.AN, ib.SEG, ib.DP, ib.FRAME} !== eb) begin
          n_fail++;
          $display("FAIL lzb_%h k=%0d got a=%b b=%b required a=%b b=%b", digits, k, {ia.AN, ia.SEG, ia.DP, ia.FRAME}, {ib.AN, ib.SEG, ib.DP, ib.FRAME}, e, eb);
        end else
          $display("[TB] lzb_%h k=%0d AN=%b SEG=%b FRAME=%b", digits, k, ia.AN, ia.SEG, ia.FRAME);
      end
    end
  endtask

  task automatic test_midframe();
    lzb = 1'b0; dp_in = 4'b0000; digits = 16'h1234;
    for (int n = 0; n < 3 * FRM; n++) begin
      if (n == FRM + 6) digits = 16'h5678;
      push_edge();
      e = q.pop_front(); eb = to_low(e); n_tests++;
      if ({ia.AN, ia.SEG, ia.DP, ia.FRAME} !== e || {ib.AN, ib.SEG, ib.DP, ib.FRAME} !== eb) begin
        n_fail++;
        $display("FAIL midframe k=%0d got a=%b b=%b required a=%b b=%b", k, {ia.AN, ia.SEG, ia.DP, ia.FRAME}, {ib.AN, ib.SEG, ib.DP, ib.FRAME}, e, eb);
      end else
        $display("[TB] midframe k=%0d AN=%b SEG=%b FRAME=%b", k, ia.AN, ia.SEG, ia.FRAME);
    end
  endtask

  task automatic test_nonbcd_dp();
    digits = 16'hA9F0; lzb = 1'b1; dp_in = 4'b0100;
    for (int n = 0; n < 2 * FRM; n++) begin
      push_edge();
      e = q.pop_front(); eb = to_low(e); n_tests++;
      if ({ia.AN, ia.SEG, ia.DP, ia.FRAME} !== e || {ib.AN, ib.SEG, ib.DP, ib.FRAME} !== eb) begin
        n_fail++;
        $display("FAIL nonbcd_dp k=%0d got a=%b b=%b required a=%b b=%b", k, {ia.AN, ia.SEG, ia.DP, ia.FRAME}, {ib.AN, ib.SEG, ib.DP, ib.FRAME}, e, eb);
      end else
        $display("[TB] nonbcd_dp k=%0d AN=%b SEG=%b DP=%b FRAME=%b", k, ia.AN, ia.SEG, ia.DP, ia.FRAME);
    end
  endtask

  task automatic test_reset_midslot();
    digits = 16'h1234; lzb = 1'b0; dp_in = 4'b0100;
    // Run until the edge that lights digit 2 mid-slot.
    for (int n = 0; n < 2 * FRM && (n < FRM || (k % FRM) != 2 * DIV + 2); n++) begin
      push_edge();
      e = q.pop_front(); eb = to_low(e); n_tests++;
      if ({ia.AN, ia.SEG, ia.DP, ia.FRAME} !== e || {ib.AN, ib.SEG, ib.DP, ib.FRAME} !== eb) begin
        n_fail++;
        $display("FAIL pre_reset k=%0d got a=%b b=%b required a=%b b=%b", k, {ia.AN, ia.SEG, ia.DP, ia.FRAME}, {ib.AN, ib.SEG, ib.DP, ib.FRAME}, e, eb);
      end else
        $display("[TB] pre_reset k=%0d AN=%b DP=%b", k, ib.AN, ib.DP);
    end
    n_tests++;
    if (ib.AN !== 4'b1011 || ib.DP !== 1'b0)
      begin n_fail++; $display("FAIL digit2_lit got AN=%b DP=%b required AN=1011 DP=0", ib.AN, ib.DP); end
    RESET = 1'b1;
    #1;
    n_tests++;
    if ({ia.AN, ia.SEG, ia.DP, ia.FRAME} !== 13'b0 || {ib.AN, ib.SEG, ib.DP, ib.FRAME} !== {12'hFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset got a=%b b=%b required a=%b b=%b", {ia.AN, ia.SEG, ia.DP, ia.FRAME}, {ib.AN, ib.SEG, ib.DP, ib.FRAME}, 13'b0, {12'hFFF, 1'b0});
    end else
      $display("[TB] async_reset AN_a=%b AN_b=%b", ia.AN, ib.AN);
    @(posedge CLK); #1;
    n_tests++;
    if ({ia.AN, ia.SEG, ia.DP, ia.FRAME} !== 13'b0)
      begin n_fail++; $display("FAIL reset_hold got %b required %b", {ia.AN, ia.SEG, ia.DP, ia.FRAME}, 13'b0); end
    RESET = 1'b0;
    k = 0;
    digits = 16'h0089;
    for (int n = 0; n < FRM; n++) begin
      push_edge();
      e = q.pop_front(); eb = to_low(e); n_tests++;
      if ({ia.AN, ia.SEG, ia.DP, ia.FRAME} !== e || {ib.AN, ib.SEG, ib.DP, ib.FRAME} !== eb) begin
        n_fail++;
        $display("FAIL post_reset k=%0d got a=%b b=%b required a=%b b=%b", k, {ia.AN, ia.SEG, ia.DP, ia.FRAME}, {ib.AN, ib.SEG, ib.DP, ib.FRAME}, e, eb);
      end else
        $display("[TB] post_reset k=%0d AN=%b SEG=%b FRAME=%b", k, ia.AN, ia.SEG, ia.FRAME);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_1234();
    test_lzb();
    test_midframe();
    test_nonbcd_dp();
    test_reset_midslot();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
